// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: bus word types, FSM states,
// requester ids and the request latch.
package mem_arb_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_e;

    typedef enum logic {
        REQ_IF,
        REQ_D
    } requester_e;

    // Request captured on acceptance; presented to memory during ACCESS.
    typedef struct packed {
        requester_e id;
        addr_t      addr;
        data_t      wdata;
        logic [3:0] wstrb;
    } req_latch_t;

    // A data request with any byte strobe set is a store.
    function automatic logic is_write(input logic [3:0] wstrb);
        return |wstrb;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on conflict; otherwise data has
// fixed priority, with a fetch force-granted once starve_cnt reaches IF_STARVE_MAX.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned IF_STARVE_MAX = 4
) (
    input  logic       if_valid,
    input  logic       d_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  requester_e last_grant,
`else
    input  logic [3:0] starve_cnt,
`endif
    output logic       grant_if,
    output logic       grant_d
);

    logic prefer_if;

    // Grant the only valid requester; on a conflict apply the mode's tie-break.
    always_comb begin
        prefer_if = 1'b0;
        grant_if  = if_valid;
        grant_d   = d_valid;
        if (if_valid && d_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prefer_if = (last_grant == REQ_D);
`else
            prefer_if = (starve_cnt == 4'(IF_STARVE_MAX));
`endif
            grant_if = prefer_if;
            grant_d  = !prefer_if;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory map between instruction fetch and
// load/store. One request in flight; response two cycles after acceptance.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// instead of data-first priority with fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned IF_STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       if_req_valid,
    output logic       if_req_ready,
    input  addr_t      if_addr,
    output logic       if_rsp_valid,
    output data_t      if_rdata,

    input  logic       d_req_valid,
    output logic       d_req_ready,
    input  addr_t      d_addr,
    input  data_t      d_wdata,
    input  logic [3:0] d_wstrb,
    output logic       d_rsp_valid,
    output data_t      d_rdata,

    output addr_t      mem_address,
    output data_t      mem_write_data,
    output logic [3:0] mem_write_enable,
    input  data_t      mem_read_data
);

    arb_state_e state;
    req_latch_t req;

    logic grant_if;
    logic grant_d;
    logic can_accept;
    logic accept_if;
    logic accept_d;
    data_t rsp_word;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    requester_e last_grant;
`else
    logic [3:0] starve_cnt;
`endif

    mem_arb_pick #(
        .IF_STARVE_MAX (IF_STARVE_MAX)
    ) u_pick (
        .if_valid   (if_req_valid),
        .d_valid    (d_req_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant (last_grant),
`else
        .starve_cnt (starve_cnt),
`endif
        .grant_if   (grant_if),
        .grant_d    (grant_d)
    );

    // Ready only toward the winner, only in states that can take a new request.
    always_comb begin
        can_accept   = !reset && (state == IDLE || state == RESP);
        if_req_ready = can_accept && grant_if;
        d_req_ready  = can_accept && grant_d;
        accept_if    = if_req_ready && if_req_valid;
        accept_d     = d_req_ready && d_req_valid;
        rsp_word     = is_write(req.wstrb) ? '0 : mem_read_data;
    end

    // Address/data hold the last latched request; strobes only during ACCESS.
    assign mem_address      = req.addr;
    assign mem_write_data   = req.wdata;
    assign mem_write_enable = (state == ACCESS) ? req.wstrb : 4'b0000;

    // Request FSM with registered responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            req          <= '0;
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (accept_if) begin
                        req   <= '{id: REQ_IF, addr: if_addr, wdata: '0, wstrb: 4'b0000};
                        state <= ACCESS;
                    end else if (accept_d) begin
                        req   <= '{id: REQ_D, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
                        state <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (req.id == REQ_IF) begin
                        if_rsp_valid <= 1'b1;
                        if_rdata     <= rsp_word;
                    end else begin
                        d_rsp_valid <= 1'b1;
                        d_rdata     <= rsp_word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember who won the most recent acceptance for the next conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_IF;
        end else if (accept_if) begin
            last_grant <= REQ_IF;
        end else if (accept_d) begin
            last_grant <= REQ_D;
        end
    end
`else
    // Count data grants taken while a fetch was waiting; cleared on a fetch grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (accept_if) begin
            starve_cnt <= 4'd0;
        end else if (accept_d && if_req_valid && starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small RAM + LEDR memory-map model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam logic [31:0] LEDR_ADDR = 32'h1000_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic       if_req_valid;
    logic       if_req_ready;
    addr_t      if_addr;
    logic       if_rsp_valid;
    data_t      if_rdata;
    logic       d_req_valid;
    logic       d_req_ready;
    addr_t      d_addr;
    data_t      d_wdata;
    logic [3:0] d_wstrb;
    logic       d_rsp_valid;
    data_t      d_rdata;
    addr_t      mem_address;
    data_t      mem_write_data;
    logic [3:0] mem_write_enable;
    data_t      mem_read_data;

    logic [31:0] ram [0:255];
    logic [9:0]  ledr = 10'd0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .IF_STARVE_MAX (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .if_req_valid     (if_req_valid),
        .if_req_ready     (if_req_ready),
        .if_addr          (if_addr),
        .if_rsp_valid     (if_rsp_valid),
        .if_rdata         (if_rdata),
        .d_req_valid      (d_req_valid),
        .d_req_ready      (d_req_ready),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_wstrb          (d_wstrb),
        .d_rsp_valid      (d_rsp_valid),
        .d_rdata          (d_rdata),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    // Memory map: combinational read, byte-enabled write at the clock edge.
    assign mem_read_data = (mem_address == LEDR_ADDR) ? {22'd0, ledr} : ram[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write_enable != 4'b0000) begin
            if (mem_address == LEDR_ADDR) begin
                ledr <= mem_write_data[9:0];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_write_enable[b]) begin
                        ram[mem_address[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the middle of the next cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " if_rsp_valid"}, 32'(if_rsp_valid), 32'd0);
        chk({tag, " d_rsp_valid"}, 32'(d_rsp_valid), 32'd0);
        chk({tag, " if_rdata"}, if_rdata, 32'd0);
        chk({tag, " d_rdata"}, d_rdata, 32'd0);
        chk({tag, " mem_address"}, mem_address, 32'd0);
        chk({tag, " mem_write_data"}, mem_write_data, 32'd0);
        chk({tag, " mem_write_enable"}, 32'(mem_write_enable), 32'd0);
    endtask

    logic exp_if [6];

    initial begin
        reset        = 1'b1;
        if_req_valid = 1'b0;
        if_addr      = '0;
        d_req_valid  = 1'b0;
        d_addr       = '0;
        d_wdata      = '0;
        d_wstrb      = 4'b0000;
        repeat (3) @(negedge clk);

        // Reset state.
        #1;
        chk("rst if_req_ready", 32'(if_req_ready), 32'd0);
        chk("rst d_req_ready", 32'(d_req_ready), 32'd0);
        chk_idle_outputs("rst");
        reset = 1'b0;
        step();

        // Preload word 4 through a data store.
        d_req_valid = 1'b1; d_addr = 32'h10; d_wdata = 32'h0010_0093; d_wstrb = 4'hF;
        #1;
        chk("pre d_req_ready", 32'(d_req_ready), 32'd1);
        step();
        d_req_valid = 1'b0;
        #1;
        chk("pre we", 32'(mem_write_enable), 32'hF);
        step();
        chk("pre d_rsp_valid", 32'(d_rsp_valid), 32'd1);
        chk("pre d_rdata", d_rdata, 32'd0);
        step();

        // Lone fetch.
        if_req_valid = 1'b1; if_addr = 32'h10;
        #1;
        chk("fetch if_req_ready", 32'(if_req_ready), 32'd1);
        chk("fetch d_req_ready", 32'(d_req_ready), 32'd0);
        step();
        if_req_valid = 1'b0;
        #1;
        chk("fetch mem_address", mem_address, 32'h10);
        chk("fetch we access", 32'(mem_write_enable), 32'd0);
        chk("fetch early rsp", 32'(if_rsp_valid), 32'd0);
        step();
        chk("fetch if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        chk("fetch if_rdata", if_rdata, 32'h0010_0093);
        chk("fetch d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        step();
        chk("fetch rsp pulse", 32'(if_rsp_valid), 32'd0);

        // Store then back-to-back load at 0x20.
        d_req_valid = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        #1;
        chk("st d_req_ready", 32'(d_req_ready), 32'd1);
        step();
        d_wstrb = 4'h0;
        #1;
        chk("st we", 32'(mem_write_enable), 32'hF);
        chk("st wdata", mem_write_data, 32'hDEAD_BEEF);
        chk("st ready in access", 32'(d_req_ready), 32'd0);
        step();
        chk("st d_rsp_valid", 32'(d_rsp_valid), 32'd1);
        chk("st d_rdata", d_rdata, 32'd0);
        chk("st we after", 32'(mem_write_enable), 32'd0);
        chk("ld accept in resp", 32'(d_req_ready), 32'd1);
        step();
        d_req_valid = 1'b0;
        #1;
        chk("ld we", 32'(mem_write_enable), 32'd0);
        chk("ld mem_address", mem_address, 32'h20);
        step();
        chk("ld d_rsp_valid", 32'(d_rsp_valid), 32'd1);
        chk("ld d_rdata", d_rdata, 32'hDEAD_BEEF);
        step();

        // LEDR store then load.
        d_req_valid = 1'b1; d_addr = LEDR_ADDR; d_wdata = 32'h2AA; d_wstrb = 4'hF;
        step();
        d_wstrb = 4'h0;
        step();
        chk("ledr value", {22'd0, ledr}, 32'h2AA);
        chk("ledr st rdata", d_rdata, 32'd0);
        step();
        d_req_valid = 1'b0;
        step();
        chk("ledr ld valid", 32'(d_rsp_valid), 32'd1);
        chk("ledr ld rdata", d_rdata, 32'h0000_02AA);
        step();

        // Reset during ACCESS of a fetch.
        if_req_valid = 1'b1; if_addr = 32'h10;
        step();
        if_req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rmid mem_address", mem_address, 32'h10);
        step();
        chk_idle_outputs("rmid");
        reset = 1'b0;
        step();
        chk("rmid no if rsp", 32'(if_rsp_valid), 32'd0);
        chk("rmid no d rsp", 32'(d_rsp_valid), 32'd0);
        d_req_valid = 1'b1; d_addr = 32'h20; d_wstrb = 4'h0;
        #1;
        chk("rmid ready", 32'(d_req_ready), 32'd1);
        step();
        d_req_valid = 1'b0;
        #1;
        chk("rmid early rsp", 32'(d_rsp_valid), 32'd0);
        step();
        chk("rmid d_rsp_valid", 32'(d_rsp_valid), 32'd1);
        chk("rmid d_rdata", d_rdata, 32'hDEAD_BEEF);
        step();

        // Contention from a fresh reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_if = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_if = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
        if_req_valid = 1'b1; if_addr = 32'h10;
        d_req_valid  = 1'b1; d_addr = 32'h20; d_wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("cont%0d if_req_ready", i), 32'(if_req_ready), 32'(exp_if[i]));
            chk($sformatf("cont%0d d_req_ready", i), 32'(d_req_ready), 32'(!exp_if[i]));
            step();
            chk($sformatf("cont%0d access ready", i), 32'({if_req_ready, d_req_ready}), 32'd0);
            step();
            chk($sformatf("cont%0d if_rsp_valid", i), 32'(if_rsp_valid), 32'(exp_if[i]));
            chk($sformatf("cont%0d d_rsp_valid", i), 32'(d_rsp_valid), 32'(!exp_if[i]));
            if (exp_if[i]) chk($sformatf("cont%0d if_rdata", i), if_rdata, 32'h0010_0093);
            else           chk($sformatf("cont%0d d_rdata", i), d_rdata, 32'hDEAD_BEEF);
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        step();
        chk("cont end state", 32'({if_rsp_valid, d_rsp_valid, mem_write_enable}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
